// File: rtl/sap_u_controller.sv
// sap_u_controller: SAP-U T-state sequencer and microcode decode (early retire via SAP_U_CTRL_EARLY_RETIRE_EN).
module sap_u_controller #(
  parameter int STEP_COUNT = 5,
  parameter int OPCODE_W = 4,
  localparam int SW = $clog2(STEP_COUNT)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ram_prog_mode,
  input  logic [OPCODE_W-1:0] instr_opcode,
  output logic                reg_a_load_n,
  output logic                reg_a_bus_enable_n,
  output logic                reg_b_load_n,
  output logic                reg_b_bus_enable_n,
  output logic                alu_enable_n,
  output logic                alu_subtract,
  output logic                ram_output_enable_n,
  output logic                ram_control_signal,
  output logic                ram_load_mar_reg,
  output logic                pc_bus_enable_n,
  output logic                pc_load_n,
  output logic                pc_increment,
  output logic                instr_load_n,
  output logic                instr_bus_enable_n,
  output logic                out_load_n,
  output logic                halted,
  output logic [SW-1:0]       ctrl_step
);
  localparam logic [OPCODE_W-1:0] OP_LDA = OPCODE_W'(4'b0000);
  localparam logic [OPCODE_W-1:0] OP_ADD = OPCODE_W'(4'b0001);
  localparam logic [OPCODE_W-1:0] OP_SUB = OPCODE_W'(4'b0010);
  localparam logic [OPCODE_W-1:0] OP_STA = OPCODE_W'(4'b0100);
  localparam logic [OPCODE_W-1:0] OP_LDI = OPCODE_W'(4'b0101);
  localparam logic [OPCODE_W-1:0] OP_JMP = OPCODE_W'(4'b0110);
  localparam logic [OPCODE_W-1:0] OP_OUT = OPCODE_W'(4'b1110);
  localparam logic [OPCODE_W-1:0] OP_HLT = OPCODE_W'(4'b1111);
  logic [SW-1:0] step_q, step_d, last;
  logic          halted_q, halted_d;
  logic          act, t0, t1, t2, t3, t4;
  logic          is_lda, is_add, is_sub, is_sta, is_ldi, is_jmp, is_out, is_hlt, is_alu;
  always_comb begin
    is_lda = instr_opcode == OP_LDA;
    is_add = instr_opcode == OP_ADD;
    is_sub = instr_opcode == OP_SUB;
    is_sta = instr_opcode == OP_STA;
    is_ldi = instr_opcode == OP_LDI;
    is_jmp = instr_opcode == OP_JMP;
    is_out = instr_opcode == OP_OUT;
    is_hlt = instr_opcode == OP_HLT;
    is_alu = is_add | is_sub;
    // reset and program mode silence the decode in the same cycle they are seen
    act = !reset && ram_prog_mode && !halted_q;
    t0 = act && step_q == SW'(0);
    t1 = act && step_q == SW'(1);
    t2 = act && step_q == SW'(2);
    t3 = act && step_q == SW'(3);
    t4 = act && step_q == SW'(4);
`ifdef SAP_U_CTRL_EARLY_RETIRE_EN
    last = (is_lda | is_sta) ? SW'(3) : (is_alu | is_hlt) ? SW'(STEP_COUNT - 1) : SW'(2);
`else
    last = SW'(STEP_COUNT - 1);
`endif
    step_d = (reset || !ram_prog_mode) ? '0 :
             halted_q ? step_q :
             step_q == last ? '0 : step_q + SW'(1);
    halted_d = reset ? 1'b0 : halted_q | (t2 & is_hlt);
  end
  always_ff @(posedge clk) begin
    step_q <= step_d;
    halted_q <= halted_d;
  end
  assign pc_bus_enable_n     = !t0;
  assign ram_load_mar_reg    = !(t0 | (t2 & (is_lda | is_alu | is_sta)));
  assign ram_output_enable_n = !(t1 | (t3 & (is_lda | is_alu)));
  assign instr_load_n        = !t1;
  assign pc_increment        = t1;
  assign instr_bus_enable_n  = !(t2 & (is_lda | is_alu | is_sta | is_ldi | is_jmp));
  assign reg_a_load_n        = !((t2 & is_ldi) | (t3 & is_lda) | (t4 & is_alu));
  assign reg_b_load_n        = !(t3 & is_alu);
  assign alu_enable_n        = !(t4 & is_alu);
  assign alu_subtract        = (t3 | t4) & is_sub;
  assign reg_a_bus_enable_n  = !((t3 & is_sta) | (t2 & is_out));
  assign reg_b_bus_enable_n  = 1'b1;
  assign ram_control_signal  = t3 & is_sta;
  assign pc_load_n           = !(t2 & is_jmp);
  assign out_load_n          = !(t2 & is_out);
  assign halted              = halted_q;
  assign ctrl_step           = step_q;
endmodule

// File: tb/tb_sap_u_controller.sv
// tb_sap_u_controller: table-driven microstep checks plus halt, program-mode and mid-instruction reset sequences.
module tb_sap_u_controller;
  localparam logic [14:0] A_LD = 15'(1) << 14, A_OE = 15'(1) << 13, B_LD = 15'(1) << 12, B_OE = 15'(1) << 11;
  localparam logic [14:0] ALU_OE = 15'(1) << 10, SUB = 15'(1) << 9, RAM_OE = 15'(1) << 8, RAM_WE = 15'(1) << 7;
  localparam logic [14:0] MAR = 15'(1) << 6, PC_OE = 15'(1) << 5, PC_LD = 15'(1) << 4, PC_INC = 15'(1) << 3;
  localparam logic [14:0] IR_LD = 15'(1) << 2, IR_OE = 15'(1) << 1, OUT_LD = 15'(1);
  localparam logic [14:0] INACT = 15'h7fff ^ SUB ^ RAM_WE ^ PC_INC;
  localparam logic [14:0] F0 = INACT ^ PC_OE ^ MAR;
  localparam logic [14:0] F1 = INACT ^ RAM_OE ^ IR_LD ^ PC_INC;
`ifdef SAP_U_CTRL_EARLY_RETIRE_EN
  localparam bit ER = 1'b1;
`else
  localparam bit ER = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1, ram_prog_mode = 1'b1;
  logic [3:0] instr_opcode = 4'h0;
  logic reg_a_load_n, reg_a_bus_enable_n, reg_b_load_n, reg_b_bus_enable_n, alu_enable_n, alu_subtract;
  logic ram_output_enable_n, ram_control_signal, ram_load_mar_reg, pc_bus_enable_n, pc_load_n;
  logic pc_increment, instr_load_n, instr_bus_enable_n, out_load_n, halted;
  logic [2:0] ctrl_step;
  logic [14:0] outs;
  int tests = 0, fails = 0;
  typedef struct {
    logic       r;
    logic       p;
    logic [3:0] op;
    logic [2:0] st;
    logic       h;
    logic [14:0] o;
  } vec_t;
  vec_t vq[$];
  always #5 clk = ~clk;
  sap_u_controller dut (
    .clk(clk), .reset(reset), .ram_prog_mode(ram_prog_mode), .instr_opcode(instr_opcode),
    .reg_a_load_n(reg_a_load_n), .reg_a_bus_enable_n(reg_a_bus_enable_n),
    .reg_b_load_n(reg_b_load_n), .reg_b_bus_enable_n(reg_b_bus_enable_n),
    .alu_enable_n(alu_enable_n), .alu_subtract(alu_subtract),
    .ram_output_enable_n(ram_output_enable_n), .ram_control_signal(ram_control_signal),
    .ram_load_mar_reg(ram_load_mar_reg), .pc_bus_enable_n(pc_bus_enable_n), .pc_load_n(pc_load_n),
    .pc_increment(pc_increment), .instr_load_n(instr_load_n), .instr_bus_enable_n(instr_bus_enable_n),
    .out_load_n(out_load_n), .halted(halted), .ctrl_step(ctrl_step)
  );
  assign outs = {reg_a_load_n, reg_a_bus_enable_n, reg_b_load_n, reg_b_bus_enable_n, alu_enable_n,
                 alu_subtract, ram_output_enable_n, ram_control_signal, ram_load_mar_reg,
                 pc_bus_enable_n, pc_load_n, pc_increment, instr_load_n, instr_bus_enable_n, out_load_n};
  function automatic void push(logic r, logic p, logic [3:0] op, int st, logic h, logic [14:0] o);
    vq.push_back('{r, p, op, 3'(st), h, o});
  endfunction
  function automatic void fetch(logic [3:0] op);
    push(0, 1, op, 0, 0, F0);
    push(0, 1, op, 1, 0, F1);
  endfunction
  function automatic void tail(logic [3:0] op, int from);
    if (!ER) for (int s = from; s < 5; s++) push(0, 1, op, s, 0, INACT);
  endfunction
  task automatic chk(string name, int got, int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask
  task automatic cyc(logic r, logic p, logic [3:0] op, int st, logic h, logic [14:0] o);
    int lows;
    reset = r;
    ram_prog_mode = p;
    instr_opcode = op;
    @(negedge clk);
    lows = int'(!reg_a_bus_enable_n) + int'(!reg_b_bus_enable_n) + int'(!alu_enable_n) +
           int'(!ram_output_enable_n) + int'(!instr_bus_enable_n) + int'(!pc_bus_enable_n);
    chk("outputs", int'(outs), int'(o));
    chk("ctrl_step", int'(ctrl_step), st);
    chk("halted", int'(halted), int'(h));
    chk("bus_invariant", int'(lows <= 1), 1);
    @(posedge clk);
    #1;
  endtask
  initial begin
    push(1, 1, 4'h0, 0, 0, INACT);
    push(1, 1, 4'h0, 0, 0, INACT);
    fetch(4'h0);
    push(0, 1, 4'h0, 2, 0, INACT ^ IR_OE ^ MAR);
    push(0, 1, 4'h0, 3, 0, INACT ^ RAM_OE ^ A_LD);
    tail(4'h0, 4);
    fetch(4'h2);
    push(0, 1, 4'h2, 2, 0, INACT ^ IR_OE ^ MAR);
    push(0, 1, 4'h2, 3, 0, INACT ^ RAM_OE ^ B_LD ^ SUB);
    push(0, 1, 4'h2, 4, 0, INACT ^ ALU_OE ^ A_LD ^ SUB);
    fetch(4'h1);
    push(0, 1, 4'h1, 2, 0, INACT ^ IR_OE ^ MAR);
    push(0, 1, 4'h1, 3, 0, INACT ^ RAM_OE ^ B_LD);
    push(0, 1, 4'h1, 4, 0, INACT ^ ALU_OE ^ A_LD);
    fetch(4'h4);
    push(0, 1, 4'h4, 2, 0, INACT ^ IR_OE ^ MAR);
    push(0, 1, 4'h4, 3, 0, INACT ^ A_OE ^ RAM_WE);
    tail(4'h4, 4);
    fetch(4'h6);
    push(0, 1, 4'h6, 2, 0, INACT ^ IR_OE ^ PC_LD);
    tail(4'h6, 3);
    fetch(4'h5);
    push(0, 1, 4'h5, 2, 0, INACT ^ IR_OE ^ A_LD);
    tail(4'h5, 3);
    fetch(4'he);
    push(0, 1, 4'he, 2, 0, INACT ^ A_OE ^ OUT_LD);
    tail(4'he, 3);
    fetch(4'h3);
    push(0, 1, 4'h3, 2, 0, INACT);
    tail(4'h3, 3);
    fetch(4'h0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    foreach (vq[i]) cyc(vq[i].r, vq[i].p, vq[i].op, vq[i].st, vq[i].h, vq[i].o);
    cyc(1, 1, 4'hf, 2, 0, INACT);
    fetch_seq(4'hf);
    cyc(0, 1, 4'hf, 2, 0, INACT);
    for (int i = 0; i < 20; i++) cyc(0, 1, 4'hf, 3, 1, INACT);
    cyc(1, 1, 4'hf, 3, 1, INACT);
    cyc(0, 1, 4'h1, 0, 0, F0);
    cyc(0, 1, 4'h1, 1, 0, F1);
    cyc(0, 1, 4'h1, 2, 0, INACT ^ IR_OE ^ MAR);
    cyc(0, 0, 4'h1, 3, 0, INACT);
    cyc(0, 0, 4'h1, 0, 0, INACT);
    cyc(0, 0, 4'h1, 0, 0, INACT);
    cyc(0, 1, 4'h1, 0, 0, F0);
    cyc(0, 1, 4'h1, 1, 0, F1);
    cyc(0, 1, 4'h1, 2, 0, INACT ^ IR_OE ^ MAR);
    cyc(1, 1, 4'h1, 3, 0, INACT);
    cyc(0, 1, 4'h1, 0, 0, F0);
    cyc(1, 0, 4'h1, 1, 0, INACT);
    cyc(0, 1, 4'h1, 0, 0, F0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  task automatic fetch_seq(logic [3:0] op);
    cyc(0, 1, op, 0, 0, F0);
    cyc(0, 1, op, 1, 0, F1);
  endtask
endmodule

// File: doc/sap_u_controller.md
Name: sap_u_controller

Overview:
- Control sequencer for the SAP-U datapath.
- Drives every control line of registers A/B, ALU, RAM/MAR, program counter, instruction register and output register. This is the hardware that performs the role the top-level benches perform by hand.
- Steps a T-state counter through fetch and execute microsteps, decoding the 4-bit opcode held in the instruction register.

Parameters:
- STEP_COUNT, 5, microsteps per instruction (T0..T4); counter width is $clog2(STEP_COUNT).
- OPCODE_W, 4, opcode width taken from the upper nibble of the instruction register.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high; clears step counter and halt latch.
- ram_prog_mode  input  1  1 = run, 0 = dipswitch programming; controller idles while 0.
- instr_opcode  input  OPCODE_W  opcode from the instruction register.
- reg_a_load_n, reg_a_bus_enable_n  output  1 each  register A load/drive, active-low.
- reg_b_load_n, reg_b_bus_enable_n  output  1 each  register B load/drive, active-low.
- alu_enable_n  output  1  ALU drives bus, active-low.
- alu_subtract  output  1  1 = A-B, 0 = A+B.
- ram_output_enable_n  output  1  RAM drives bus, active-low.
- ram_control_signal  output  1  1 = write bus into RAM[MAR].
- ram_load_mar_reg  output  1  MAR load from bus, active-low.
- pc_bus_enable_n, pc_load_n  output  1 each  PC drive/load, active-low.
- pc_increment  output  1  PC +1 at the next edge.
- instr_load_n, instr_bus_enable_n  output  1 each  IR load; IR drives its low nibble (operand) onto the bus.
- out_load_n  output  1  output register load, active-low.
- halted  output  1  halt latch.
- ctrl_step  output  $clog2(STEP_COUNT)  current T-state, for debug.

Behaviour:
- Outputs are combinational decode of (ctrl_step, instr_opcode, halted, ram_prog_mode).
- Inactive state for all outputs: all *_n = 1; alu_subtract = 0; ram_control_signal = 0; pc_increment = 0.
- Reset: ctrl_step = 0, halted = 0. All outputs inactive in the same cycle reset is sampled, including mid-instruction.
- The step counter advances by 1 per clock and wraps STEP_COUNT-1 -> 0.
- Fetch, all opcodes:
  - T0: pc_bus_enable_n = 0, ram_load_mar_reg = 0.
  - T1: ram_output_enable_n = 0, instr_load_n = 0, pc_increment = 1.
- Execute:
  - LDA 0000: T2 IR out + MAR load; T3 RAM out + A load.
  - ADD 0001: T2 IR out + MAR load; T3 RAM out + B load; T4 ALU out + A load, alu_subtract = 0.
  - SUB 0010: same as ADD with alu_subtract = 1 in T3 and T4.
  - STA 0100: T2 IR out + MAR load; T3 A out + ram_control_signal = 1.
  - LDI 0101: T2 IR out + A load.
  - JMP 0110: T2 IR out + pc_load_n = 0.
  - OUT 1110: T2 A out + out_load_n = 0.
  - HLT 1111: halted sets at the end of T2 and holds until reset. While halted, the counter is frozen and all outputs are inactive.
  - All other opcodes are NOP; execute steps are inactive.
- Bus invariant: at most one of the *_bus_enable_n / alu_enable_n / ram_output_enable_n / instr_bus_enable_n signals is low in any cycle.
- Program mode (ram_prog_mode = 0): counter forced to 0 at each edge, outputs inactive, halted unchanged. On return to 1, fetch starts at T0 on the next cycle.
- Reset wins over program mode and halt.

Optional Feature:
- Macro: SAP_U_CTRL_EARLY_RETIRE_EN.
- Defined: after the last active microstep of an instruction, the counter returns to T0 on the next edge.
  - LDA/STA end after T3; LDI/JMP/OUT/NOP end after T2; ADD/SUB use all 5 steps.
- Undefined: every instruction takes exactly STEP_COUNT cycles; unused steps are inactive.

Test Plan:
- Reset held 2 cycles then released, ram_prog_mode = 1, opcode 0000 -> first cycle ctrl_step = 0 with pc_bus_enable_n = 0 and ram_load_mar_reg = 0; next cycle instr_load_n = 0, pc_increment = 1.
- Opcode 0010 through T0..T4 -> T3: ram_output_enable_n = 0, reg_b_load_n = 0, alu_subtract = 1; T4: alu_enable_n = 0, reg_a_load_n = 0; counter wraps to 0.
- Opcode 0100 -> T3: reg_a_bus_enable_n = 0 and ram_control_signal = 1. Opcode 0110 -> T2: instr_bus_enable_n = 0 and pc_load_n = 0.
- Opcode 1111 -> halted = 1 after T2, ctrl_step frozen, all outputs inactive for 20 cycles; reset -> halted = 0, ctrl_step = 0.
- ram_prog_mode dropped at T3 of ADD -> ctrl_step = 0 and outputs inactive next cycle; restored -> fetch at T0.
- With SAP_U_CTRL_EARLY_RETIRE_EN, opcode 0101 -> sequence 0,1,2,0; without it -> 0,1,2,3,4,0. Every cycle of every test checks the bus invariant.
